// File: rtl/host_interface_master_if.sv
`default_nettype none
// ============================================================================
// host_interface_master_if
//   Command/response handshake plus the state/ctl/data/rdy host register bus.
//   Revision: 1.0
// ============================================================================
interface host_interface_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [15:0] cmd_ep;
    logic [15:0] cmd_reg;
    logic [15:0] cmd_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_timeout;
    logic [3:0]  state;
    logic [2:0]  ctl;
    logic        rdy;
    logic [15:0] data_out;
    logic        data_oe;
    logic [15:0] data_in;

    modport master (
        input  cmd_valid, cmd_write, cmd_ep, cmd_reg, cmd_wdata, rdy, data_in,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_timeout, state, ctl,
               data_out, data_oe
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_ep, cmd_reg, cmd_wdata, rdy, data_in,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_timeout, state, ctl,
               data_out, data_oe
    );
endinterface
`default_nettype wire

// File: rtl/host_interface_master.sv
`default_nettype none
// ============================================================================
// host_interface_master
//   Sequences single register write/read commands onto the host register bus,
//   skipping SETEP/SETREG phases when the cached address already matches.
//   Revision: 1.0
// ============================================================================
module host_interface_master #(
    parameter int SETTLE_CYCLES = 2,
    parameter int TIMEOUT       = 255
) (
    input  wire logic             if_clock,
    input  wire logic             resetb,
    host_interface_master_if.master bus
);

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_EP_SETTLE  = 4'd1,
        ST_EP_STROBE  = 4'd2,
        ST_REG_SETTLE = 4'd3,
        ST_REG_STROBE = 4'd4,
        ST_VAL_SETTLE = 4'd5,
        ST_VAL_STROBE = 4'd6,
        ST_RD_SETTLE  = 4'd7,
        ST_RD_STROBE  = 4'd8,
        ST_RD_WAIT    = 4'd9,
        ST_DONE       = 4'd10
    } fsm_t;

    localparam logic [3:0]  CODE_IDLE    = 4'd0;
    localparam logic [3:0]  CODE_SETEP   = 4'd1;
    localparam logic [3:0]  CODE_SETREG  = 4'd2;
    localparam logic [3:0]  CODE_SETRVAL = 4'd3;
    localparam logic [3:0]  CODE_RDDATA  = 4'd4;
    localparam logic [15:0] SETTLE_LAST  = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    fsm_t        fsm_q, fsm_d;
    logic [15:0] cnt_q, cnt_d;
    logic        write_q, write_d;
    logic [15:0] ep_q, ep_d;
    logic [15:0] reg_q, reg_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] ep_cache_q, ep_cache_d;
    logic        ep_valid_q, ep_valid_d;
    logic [15:0] reg_cache_q, reg_cache_d;
    logic        reg_valid_q, reg_valid_d;

    logic        cmd_ready_q, cmd_ready_d;
    logic [3:0]  code_q, code_d;
    logic        strobe_q, strobe_d;
    logic [15:0] dout_q, dout_d;
    logic        oe_q, oe_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [15:0] rdata_q, rdata_d;
    logic        timeout_q, timeout_d;

    logic        accept;
    logic        acc_ep_miss;
    logic        acc_reg_miss;
    logic        reg_miss;
    fsm_t        final_phase;

    assign accept       = bus.cmd_valid && cmd_ready_q;
    assign acc_ep_miss  = !ep_valid_q  || (bus.cmd_ep  != ep_cache_q);
    assign acc_reg_miss = !reg_valid_q || (bus.cmd_reg != reg_cache_q);
    // The REG cache cannot change between accept and the REG decision.
    assign reg_miss     = !reg_valid_q || (reg_q != reg_cache_q);
    assign final_phase  = write_q ? ST_VAL_SETTLE : ST_RD_SETTLE;

    always_comb begin
        fsm_d       = fsm_q;
        cnt_d       = cnt_q;
        write_d     = write_q;
        ep_d        = ep_q;
        reg_d       = reg_q;
        wdata_d     = wdata_q;
        ep_cache_d  = ep_cache_q;
        ep_valid_d  = ep_valid_q;
        reg_cache_d = reg_cache_q;
        reg_valid_d = reg_valid_q;
        rdata_d     = rdata_q;
        timeout_d   = timeout_q;

        case (fsm_q)
            ST_IDLE: begin
                if (accept) begin
                    write_d = bus.cmd_write;
                    ep_d    = bus.cmd_ep;
                    reg_d   = bus.cmd_reg;
                    wdata_d = bus.cmd_wdata;
                    cnt_d   = 16'd0;
                    if (acc_ep_miss)       fsm_d = ST_EP_SETTLE;
                    else if (acc_reg_miss) fsm_d = ST_REG_SETTLE;
                    else if (bus.cmd_write) fsm_d = ST_VAL_SETTLE;
                    else                   fsm_d = ST_RD_SETTLE;
                end
            end
            ST_EP_SETTLE, ST_REG_SETTLE, ST_VAL_SETTLE, ST_RD_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    fsm_d = fsm_t'(fsm_q + 4'd1);
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_EP_STROBE: begin
                ep_cache_d = ep_q;
                ep_valid_d = 1'b1;
                cnt_d      = 16'd0;
                fsm_d      = reg_miss ? ST_REG_SETTLE : final_phase;
            end
            ST_REG_STROBE: begin
                reg_cache_d = reg_q;
                reg_valid_d = 1'b1;
                cnt_d       = 16'd0;
                fsm_d       = final_phase;
            end
            ST_VAL_STROBE: begin
                rdata_d   = 16'd0;
                timeout_d = 1'b0;
                fsm_d     = ST_DONE;
            end
            ST_RD_STROBE: begin
                cnt_d = 16'd0;
                fsm_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (bus.rdy) begin
                    rdata_d   = bus.data_in;
                    timeout_d = 1'b0;
                    fsm_d     = ST_DONE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    // A silent device leaves its address state unknown.
                    rdata_d     = 16'd0;
                    timeout_d   = 1'b1;
                    ep_valid_d  = 1'b0;
                    reg_valid_d = 1'b0;
                    fsm_d       = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_DONE: begin
                fsm_d = ST_IDLE;
            end
            default: begin
                fsm_d = ST_IDLE;
            end
        endcase

        // Bus outputs are decoded from the next state so they are registered.
        cmd_ready_d = 1'b0;
        code_d      = CODE_IDLE;
        strobe_d    = 1'b0;
        dout_d      = 16'd0;
        oe_d        = 1'b0;
        rsp_valid_d = 1'b0;
        case (fsm_d)
            ST_IDLE: begin
                cmd_ready_d = 1'b1;
            end
            ST_EP_SETTLE, ST_EP_STROBE: begin
                code_d   = CODE_SETEP;
                dout_d   = ep_d;
                oe_d     = 1'b1;
                strobe_d = (fsm_d == ST_EP_STROBE);
            end
            ST_REG_SETTLE, ST_REG_STROBE: begin
                code_d   = CODE_SETREG;
                dout_d   = reg_d;
                oe_d     = 1'b1;
                strobe_d = (fsm_d == ST_REG_STROBE);
            end
            ST_VAL_SETTLE, ST_VAL_STROBE: begin
                code_d   = CODE_SETRVAL;
                dout_d   = wdata_d;
                oe_d     = 1'b1;
                strobe_d = (fsm_d == ST_VAL_STROBE);
            end
            ST_RD_SETTLE, ST_RD_STROBE, ST_RD_WAIT: begin
                code_d   = CODE_RDDATA;
                strobe_d = (fsm_d == ST_RD_STROBE);
            end
            ST_DONE: begin
                rsp_valid_d = 1'b1;
            end
            default: begin
                cmd_ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge if_clock) begin
        if (!resetb) begin
            fsm_q       <= ST_IDLE;
            cnt_q       <= 16'd0;
            write_q     <= 1'b0;
            ep_q        <= 16'd0;
            reg_q       <= 16'd0;
            wdata_q     <= 16'd0;
            ep_cache_q  <= 16'd0;
            ep_valid_q  <= 1'b0;
            reg_cache_q <= 16'd0;
            reg_valid_q <= 1'b0;
            cmd_ready_q <= 1'b0;
            code_q      <= CODE_IDLE;
            strobe_q    <= 1'b0;
            dout_q      <= 16'd0;
            oe_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= 16'd0;
            timeout_q   <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            ep_q        <= ep_d;
            reg_q       <= reg_d;
            wdata_q     <= wdata_d;
            ep_cache_q  <= ep_cache_d;
            ep_valid_q  <= ep_valid_d;
            reg_cache_q <= reg_cache_d;
            reg_valid_q <= reg_valid_d;
            cmd_ready_q <= cmd_ready_d;
            code_q      <= code_d;
            strobe_q    <= strobe_d;
            dout_q      <= dout_d;
            oe_q        <= oe_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rdata_q;
    assign bus.rsp_timeout = timeout_q;
    assign bus.state       = code_q;
    assign bus.ctl         = {1'b0, strobe_q, 1'b0};
    assign bus.data_out    = dout_q;
    assign bus.data_oe     = oe_q;

endmodule
`default_nettype wire
